// File: rtl/mul_seq_pkg.sv
// Shared ALU opcode definitions for the multiplier and the ALU it drives.
package mul_seq_pkg;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
endpackage

// File: rtl/mul_seq_alu.sv
// Combinational ALU shared by sequential datapath blocks; wired next to mul_seq.
module mul_seq_alu
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_op,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero
);
   // Shifts move i_b by the amount in i_a.
   always_comb begin
      o_result = '0;
      case (i_op)
         ALU_ADD: o_result = i_a + i_b;
         ALU_SUB: o_result = i_a - i_b;
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_XOR: o_result = i_a ^ i_b;
         ALU_SLL: o_result = i_b << i_a;
         ALU_SRL: o_result = i_b >> i_a;
         default: o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);
endmodule

// File: rtl/mul_seq.sv
// Shift-and-add multiplier that borrows an external ALU for every add and shift.
// Fixed 2*WIDTH-cycle iteration, result is the low WIDTH bits of op_a*op_b.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CW-1:0]    r_cnt;
   logic             w_unused;

   assign w_unused = alu_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         product  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_acc    <= '0;
                  r_mcand  <= op_a;
                  r_mplier <= op_b;
                  r_cnt    <= '0;
                  busy     <= 1'b1;
                  r_state  <= S_ADD;
               end
            end
            S_ADD: begin
               r_acc   <= alu_result;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               r_mcand  <= alu_result;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               // Last add already landed in r_acc, so it is the final product.
               if (r_cnt == CW'(WIDTH - 1)) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  product <= r_acc;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_ADD;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      alu_op = ALU_ADD;
      alu_a  = '0;
      alu_b  = '0;
      case (r_state)
         S_ADD: begin
            alu_a = r_acc;
            alu_b = r_mplier[0] ? r_mcand : '0;
         end
         S_SHIFT: begin
            alu_op = ALU_SLL;
            alu_a  = WIDTH'(1);
            alu_b  = r_mcand;
         end
         default: ;
      endcase
   end
endmodule
